key_pulse_gen: RTL and testbench
================================

KEY_PULSE_GEN -- requirements
Module: key_pulse_gen

Interface
REQ-001 Parameter DEBOUNCE_CNT, default 20, is the number of clk cycles a synchronised key level must hold before it is accepted (legal range 2..65535).
REQ-002 Parameter REPEAT_DLY, default 1000, is the clk cycles from the accepted press pulse to the first auto-repeat pulse.
REQ-003 Parameter REPEAT_PER, default 200, is the clk cycles between successive auto-repeat pulses.
REQ-004 Port clk, input, 1, is the single clock; all state is clocked on its rising edge.
REQ-005 Port rst, input, 1, is the reset: asynchronous, active-high.
REQ-006 Port key1_n, input, 1, is raw button 1, active-low, asynchronous to clk, may bounce.
REQ-007 Port key2_n, input, 1, is raw button 2, with the same properties as key1_n.
REQ-008 Port en1, output, 1, is a registered single-cycle pulse: button 1 accepted press (the select-3 request to the downstream pulse counter).
REQ-009 Port en2, output, 1, is a registered single-cycle pulse: button 2 accepted press (the select-2 request).

Function
REQ-010 Each key SHALL pass through a 2-flop synchroniser before any other logic; the synchroniser reset value is 1 (released).
REQ-011 Each key SHALL have an independent 4-state FSM with states IDLE, PRESS_WAIT, HELD and REL_WAIT.
REQ-012 IDLE: a synced low SHALL move the FSM to PRESS_WAIT and clear the debounce counter.
REQ-013 PRESS_WAIT: a synced high SHALL return the FSM to IDLE; the counter reaching DEBOUNCE_CNT-1 with the synced level still low SHALL move it to HELD and raise the press strobe for one cycle.
REQ-014 HELD: a synced high SHALL move the FSM to REL_WAIT and clear the counter.
REQ-015 REL_WAIT: a synced low SHALL return the FSM to HELD with no strobe; the counter reaching DEBOUNCE_CNT-1 with the synced level still high SHALL move it to IDLE.
REQ-016 Latency: an enN pulse SHALL assert exactly DEBOUNCE_CNT+3 clk edges after the first edge that samples keyN_n low, provided the key stays low throughout.
REQ-017 en1 and en2 SHALL each be high for exactly one cycle per strobe, and never in two consecutive cycles.
REQ-018 Simultaneous strobes: when both strobes occur in the same cycle, en1 SHALL assert, the en2 strobe SHALL be dropped, and en2 SHALL be 0.
REQ-019 A release SHALL NOT generate any pulse.
REQ-020 Debounce counters SHALL saturate and never wrap; the counter width is clog2(DEBOUNCE_CNT).

Reset
REQ-021 While rst is high: both FSMs SHALL be in IDLE, all counters 0, synchronisers 1, en1=0 and en2=0.
REQ-022 Reset asserted mid-debounce or mid-repeat SHALL abort the operation with no pulse.
REQ-023 After rst deasserts with a key already held low, the full debounce SHALL be required, yielding one pulse at DEBOUNCE_CNT+3 edges.

Configuration
REQ-024 With macro KEY_PULSE_REPEAT_EN defined, a key remaining in HELD SHALL produce additional strobes: the first REPEAT_DLY cycles after the press strobe, then one every REPEAT_PER cycles until it leaves HELD.
REQ-025 Repeat timers SHALL reset on entry to HELD from PRESS_WAIT and on entry to REL_WAIT.
REQ-026 A REL_WAIT->HELD bounce SHALL resume repeat timing from 0 and SHALL NOT produce an immediate strobe.
REQ-027 Without KEY_PULSE_REPEAT_EN, no repeat logic or parameters SHALL be synthesised and exactly one pulse SHALL be produced per accepted press.

Structure
REQ-028 Package key_pulse_pkg SHALL hold the FSM state enum (IDLE, PRESS_WAIT, HELD, REL_WAIT) and the default constants for DEBOUNCE_CNT, REPEAT_DLY and REPEAT_PER.
REQ-029 Sub-module key_debounce (synchroniser + FSM + optional repeat, one strobe output) SHALL be instantiated twice.
REQ-030 The top level SHALL contain only the priority merge and the output registers.

Verification (DEBOUNCE_CNT=4, REPEAT_DLY=20, REPEAT_PER=8)
REQ-031 Clean press: key1_n held low 50 cycles -> one en1 pulse 7 edges after the first low sample; en2=0.
REQ-032 Bounce: key2_n toggling with low runs of 3 cycles, then held low -> no en2 until a 4-cycle stable low, then exactly one en2 pulse.
REQ-033 Simultaneous: both keys fall on the same edge -> en1 pulses, en2 stays 0 throughout.
REQ-034 Reset: rst asserted 2 cycles into PRESS_WAIT -> no pulse; keeping key1_n low after reset -> en1 7 edges after rst deasserts.
REQ-035 Release glitch: in HELD, key1_n high for 2 cycles then low -> no en1 pulse.
REQ-036 Repeat (KEY_PULSE_REPEAT_EN): key1_n held 60 cycles -> en1 at edge 7, 27, 35, 43, 51, 59.

Source files
------------

// File: rtl/key_pulse_pkg.sv
// Shared types and default constants for the two-button press pulse generator.
package key_pulse_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_WAIT = 2'd1,
      HELD       = 2'd2,
      REL_WAIT   = 2'd3
   } key_state_t;

   localparam int unsigned DEF_DEBOUNCE_CNT = 20;
   localparam int unsigned DEF_REPEAT_DLY   = 1000;
   localparam int unsigned DEF_REPEAT_PER   = 200;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One button: 2-flop synchroniser, debounce FSM and registered press strobe.
// Auto-repeat while held is built only when KEY_PULSE_REPEAT_EN is defined.
module key_debounce
   import key_pulse_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
`ifdef KEY_PULSE_REPEAT_EN
   ,
   parameter int unsigned REPEAT_DLY   = DEF_REPEAT_DLY,
   parameter int unsigned REPEAT_PER   = DEF_REPEAT_PER
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic strobe
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CNT);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

   key_state_t    state, state_n;
   logic [1:0]    sync_q;
   logic          synced;
   logic [CW-1:0] cnt, cnt_n;
   logic          strobe_n;

`ifdef KEY_PULSE_REPEAT_EN
   localparam int unsigned TW = $clog2(max_u(REPEAT_DLY, REPEAT_PER) + 1);
   localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DLY - 1);
   localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PER - 1);

   logic [TW-1:0] timer, timer_n;
   logic          rep, rep_n;       // 0: waiting first delay, 1: periodic phase
`endif

   assign synced = sync_q[1];

   // Synchroniser resets to released so reset never looks like a press
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= 2'b11;
      else     sync_q <= {sync_q[0], key_n};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         strobe <= 1'b0;
`ifdef KEY_PULSE_REPEAT_EN
         timer  <= '0;
         rep    <= 1'b0;
`endif
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         strobe <= strobe_n;
`ifdef KEY_PULSE_REPEAT_EN
         timer  <= timer_n;
         rep    <= rep_n;
`endif
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      strobe_n = 1'b0;
`ifdef KEY_PULSE_REPEAT_EN
      timer_n  = timer;
      rep_n    = rep;
`endif
      case (state)
         IDLE: begin
            if (!synced) begin
               state_n = PRESS_WAIT;
               cnt_n   = '0;
            end
         end
         PRESS_WAIT: begin
            if (synced) begin
               state_n = IDLE;
            end else if (cnt == CNT_LAST) begin
               state_n  = HELD;
               strobe_n = 1'b1;
`ifdef KEY_PULSE_REPEAT_EN
               timer_n  = '0;
               rep_n    = 1'b0;
`endif
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         HELD: begin
            if (synced) begin
               state_n = REL_WAIT;
               cnt_n   = '0;
`ifdef KEY_PULSE_REPEAT_EN
               timer_n = '0;
               rep_n   = 1'b0;
`endif
            end
`ifdef KEY_PULSE_REPEAT_EN
            else if (timer == (rep ? PER_LAST : DLY_LAST)) begin
               strobe_n = 1'b1;
               timer_n  = '0;
               rep_n    = 1'b1;
            end else if (timer != '1) begin
               timer_n = timer + TW'(1);
            end
`endif
         end
         REL_WAIT: begin
            // A bounce back to low resumes holding without a new strobe
            if (!synced) begin
               state_n = HELD;
               cnt_n   = '0;
`ifdef KEY_PULSE_REPEAT_EN
               timer_n = '0;
               rep_n   = 1'b0;
`endif
            end else if (cnt == CNT_LAST) begin
               state_n = IDLE;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: rtl/key_pulse_gen.sv
// Two debounced buttons merged into registered select pulses; button 1 wins ties.
// Define KEY_PULSE_REPEAT_EN to enable auto-repeat while a button is held.
module key_pulse_gen
   import key_pulse_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
`ifdef KEY_PULSE_REPEAT_EN
   ,
   parameter int unsigned REPEAT_DLY   = DEF_REPEAT_DLY,
   parameter int unsigned REPEAT_PER   = DEF_REPEAT_PER
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic key1_n,
   input  logic key2_n,
   output logic en1,
   output logic en2
);

   logic strobe1;
   logic strobe2;

   key_debounce #(
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
`ifdef KEY_PULSE_REPEAT_EN
      ,
      .REPEAT_DLY   (REPEAT_DLY),
      .REPEAT_PER   (REPEAT_PER)
`endif
   ) u_key1 (
      .clk    (clk),
      .rst    (rst),
      .key_n  (key1_n),
      .strobe (strobe1)
   );

   key_debounce #(
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
`ifdef KEY_PULSE_REPEAT_EN
      ,
      .REPEAT_DLY   (REPEAT_DLY),
      .REPEAT_PER   (REPEAT_PER)
`endif
   ) u_key2 (
      .clk    (clk),
      .rst    (rst),
      .key_n  (key2_n),
      .strobe (strobe2)
   );

   // Coincident strobes: button 2 is dropped, not deferred
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en1 <= 1'b0;
         en2 <= 1'b0;
      end else begin
         en1 <= strobe1;
         en2 <= strobe2 & ~strobe1;
      end
   end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Directed bench for key_pulse_gen with DEBOUNCE_CNT=4 (pulse 7 edges after first low sample).
module tb_key_pulse_gen;

   localparam int unsigned D = 4;
`ifdef KEY_PULSE_REPEAT_EN
   localparam int unsigned DLY = 20;
   localparam int unsigned PER = 8;
`endif

   logic clk = 1'b0;
   logic rst;
   logic key1_n;
   logic key2_n;
   logic en1;
   logic en2;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   key_pulse_gen #(
      .DEBOUNCE_CNT (D)
`ifdef KEY_PULSE_REPEAT_EN
      ,
      .REPEAT_DLY   (DLY),
      .REPEAT_PER   (PER)
`endif
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .key1_n (key1_n),
      .key2_n (key2_n),
      .en1    (en1),
      .en2    (en2)
   );

   // Drive at the falling edge, then sample 1 time unit after the next rising edge
   task automatic step(input logic k1, input logic k2, input logic r);
      @(negedge clk);
      key1_n = k1;
      key2_n = k2;
      rst    = r;
      @(posedge clk);
      #1;
   endtask

   // Expected pulse after edge k for a key held low on edges 0..n-1, then released
   function automatic logic held_pulse(input int k, input int n);
      if (k == 7) return 1'b1;
`ifdef KEY_PULSE_REPEAT_EN
      if (k >= 27 && k <= n + 2 && ((k - 27) % 8) == 0) return 1'b1;
`endif
      return 1'b0;
   endfunction

   task automatic test_reset();
      rst = 1'b1; key1_n = 1'b1; key2_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (en1 !== 1'b0) begin tests_failed++; $display("FAIL reset_en1 got=%b expected=0", en1); end
      tests_run++;
      if (en2 !== 1'b0) begin tests_failed++; $display("FAIL reset_en2 got=%b expected=0", en2); end
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 1'b1, 1'b0);
         tests_run++;
         if (en1 !== 1'b0 || en2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle k=%0d en1=%b en2=%b expected 0 0", k, en1, en2);
         end
      end
   endtask

   task automatic test_clean_press();
      logic exp1;
      for (int k = 0; k < 62; k++) begin
         step((k < 50) ? 1'b0 : 1'b1, 1'b1, 1'b0);
         exp1 = held_pulse(k, 50);
         tests_run++;
         if (en1 !== exp1) begin tests_failed++; $display("FAIL clean_en1 k=%0d got=%b expected=%b", k, en1, exp1); end
         tests_run++;
         if (en2 !== 1'b0) begin tests_failed++; $display("FAIL clean_en2 k=%0d got=%b expected=0", k, en2); end
      end
   endtask

   task automatic test_bounce();
      logic k2;
      logic exp2;
      for (int k = 0; k < 47; k++) begin
         if (k < 15) k2 = ((k % 5) < 3) ? 1'b0 : 1'b1;
         else        k2 = (k < 35) ? 1'b0 : 1'b1;
         step(1'b1, k2, 1'b0);
         exp2 = (k == 22);
         tests_run++;
         if (en2 !== exp2) begin tests_failed++; $display("FAIL bounce_en2 k=%0d got=%b expected=%b", k, en2, exp2); end
         tests_run++;
         if (en1 !== 1'b0) begin tests_failed++; $display("FAIL bounce_en1 k=%0d got=%b expected=0", k, en1); end
      end
   endtask

   task automatic test_simultaneous();
      logic exp1;
      for (int k = 0; k < 42; k++) begin
         step((k < 30) ? 1'b0 : 1'b1, (k < 30) ? 1'b0 : 1'b1, 1'b0);
         exp1 = held_pulse(k, 30);
         tests_run++;
         if (en1 !== exp1) begin tests_failed++; $display("FAIL simul_en1 k=%0d got=%b expected=%b", k, en1, exp1); end
         tests_run++;
         if (en2 !== 1'b0) begin tests_failed++; $display("FAIL simul_en2 k=%0d got=%b expected=0", k, en2); end
      end
   endtask

   task automatic test_reset_abort();
      logic exp1;
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b1, 1'b0);
         tests_run++;
         if (en1 !== 1'b0) begin tests_failed++; $display("FAIL abort_pre k=%0d got=%b expected=0", k, en1); end
      end
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b1, 1'b1);
         tests_run++;
         if (en1 !== 1'b0 || en2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_rst k=%0d en1=%b en2=%b expected 0 0", k, en1, en2);
         end
      end
      for (int k = 0; k < 32; k++) begin
         step((k < 20) ? 1'b0 : 1'b1, 1'b1, 1'b0);
         exp1 = held_pulse(k, 20);
         tests_run++;
         if (en1 !== exp1) begin tests_failed++; $display("FAIL abort_post k=%0d got=%b expected=%b", k, en1, exp1); end
      end
   endtask

   task automatic test_release_glitch();
      logic k1;
      logic exp1;
      for (int k = 0; k < 52; k++) begin
         k1 = (k < 40 && k != 20 && k != 21) ? 1'b0 : 1'b1;
         step(k1, 1'b1, 1'b0);
         exp1 = (k == 7);
         tests_run++;
         if (en1 !== exp1) begin tests_failed++; $display("FAIL glitch_en1 k=%0d got=%b expected=%b", k, en1, exp1); end
      end
   endtask

   task automatic test_hold_long();
      logic exp1;
      for (int k = 0; k < 72; k++) begin
         step((k < 60) ? 1'b0 : 1'b1, 1'b1, 1'b0);
`ifdef KEY_PULSE_REPEAT_EN
         exp1 = (k == 7 || k == 27 || k == 35 || k == 43 || k == 51 || k == 59);
`else
         exp1 = (k == 7);
`endif
         tests_run++;
         if (en1 !== exp1) begin tests_failed++; $display("FAIL hold_en1 k=%0d got=%b expected=%b", k, en1, exp1); end
         tests_run++;
         if (en2 !== 1'b0) begin tests_failed++; $display("FAIL hold_en2 k=%0d got=%b expected=0", k, en2); end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_simultaneous();
      test_reset_abort();
      test_release_glitch();
      test_hold_long();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
